// File: rtl/yin_tau_picker_if.sv
// Streaming port bundle for the YIN tau picker: d(t) beats in, tau/unvoiced pulses out.
interface yin_tau_picker_if;
    logic [31:0] diff_in;
    logic        diff_valid_in;
    logic        diff_last_in;
    logic [7:0]  threshold_in;
    logic [10:0] tau_out;
    logic        tau_valid_out;
    logic        unvoiced_out;

    modport master (
        output diff_in, diff_valid_in, diff_last_in, threshold_in,
        input  tau_out, tau_valid_out, unvoiced_out
    );

    modport slave (
        input  diff_in, diff_valid_in, diff_last_in, threshold_in,
        output tau_out, tau_valid_out, unvoiced_out
    );
endinterface

// File: rtl/yin_tau_picker.sv
// Picks the first local-minimum lag whose cumulative-mean-normalised difference falls below a
// threshold, using a cross-multiplied compare instead of a divider. Three-stage pipeline.
module yin_tau_picker #(
    parameter int unsigned MaxTau     = 2047,
    parameter int unsigned MinTau     = 20,
    parameter int unsigned ThreshFrac = 8
) (
    input logic             clk_in,
    input logic             rst_in,
    yin_tau_picker_if.slave pick_io
);
    localparam int unsigned TauW = 11;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 48;
    localparam int unsigned SWP  = SW + 1;
    localparam int unsigned PW   = DW + TauW + ThreshFrac;
    localparam int unsigned QW   = 8 + SW;

    typedef enum logic [1:0] {StAccum, StDescend, StDrain} state_e;

    // Beat counter, running sum and per-frame threshold
    logic [TauW-1:0] t_q;
    logic [SW-1:0]   s_q, s_d;
    logic [7:0]      thr_q, thr_d;
    logic            first_beat, last_eff;
    logic [SW:0]     sum_wide;

    always_comb begin
        first_beat = (t_q == '0);
        last_eff   = pick_io.diff_last_in || (t_q == TauW'(MaxTau));
        sum_wide   = {1'b0, s_q} + SWP'(pick_io.diff_in);
        // d(0) never enters the sum; saturate rather than wrap
        if (first_beat)        s_d = '0;
        else if (sum_wide[SW]) s_d = '1;
        else                   s_d = sum_wide[SW-1:0];
        thr_d = first_beat ? pick_io.threshold_in : thr_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            t_q   <= '0;
            s_q   <= '0;
            thr_q <= '0;
        end else if (pick_io.diff_valid_in) begin
            t_q   <= last_eff ? '0 : t_q + 1'b1;
            s_q   <= s_d;
            thr_q <= thr_d;
        end
    end

    // Stage 1: capture beat with its lag and S(t)
    logic            v1_q, last1_q;
    logic [DW-1:0]   d1_q;
    logic [TauW-1:0] t1_q;
    logic [SW-1:0]   s1_q;
    logic [7:0]      thr1_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            d1_q    <= '0;
            t1_q    <= '0;
            s1_q    <= '0;
            thr1_q  <= '0;
        end else begin
            v1_q <= pick_io.diff_valid_in;
            if (pick_io.diff_valid_in) begin
                last1_q <= last_eff;
                d1_q    <= pick_io.diff_in;
                t1_q    <= t_q;
                s1_q    <= s_d;
                thr1_q  <= thr_d;
            end
        end
    end

    // Stage 2: d*t/S < thr  <=>  (d*t << frac) < thr*S
    logic            v2_q, last2_q, elig2_q;
    logic [DW-1:0]   d2_q;
    logic [TauW-1:0] t2_q;
    logic [PW-1:0]   p2_q, p_d;
    logic [QW-1:0]   q2_q, q_d;
    logic            elig_d;

    always_comb begin
        p_d    = (PW'(d1_q) * PW'(t1_q)) << ThreshFrac;
        q_d    = QW'(thr1_q) * QW'(s1_q);
        elig_d = (t1_q >= TauW'(MinTau)) && (s1_q != '0);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            elig2_q <= 1'b0;
            d2_q    <= '0;
            t2_q    <= '0;
            p2_q    <= '0;
            q2_q    <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                last2_q <= last1_q;
                elig2_q <= elig_d;
                d2_q    <= d1_q;
                t2_q    <= t1_q;
                p2_q    <= p_d;
                q2_q    <= q_d;
            end
        end
    end

    // Stage 3: threshold decision and minimum-tracking FSM
    state_e          state_q;
    logic [TauW-1:0] cand_t_q, tau_q;
    logic [DW-1:0]   cand_d_q;
    logic            tau_valid_q, unvoiced_q;
    logic            below;

    assign below = elig2_q && (QW'(p2_q) < q2_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StAccum;
            cand_t_q    <= '0;
            cand_d_q    <= '0;
            tau_q       <= '0;
            tau_valid_q <= 1'b0;
            unvoiced_q  <= 1'b0;
        end else begin
            tau_valid_q <= 1'b0;
            unvoiced_q  <= 1'b0;
            if (v2_q) begin
                case (state_q)
                    StAccum: begin
                        if (below && last2_q) begin
                            tau_q       <= t2_q;
                            tau_valid_q <= 1'b1;
                        end else if (below) begin
                            cand_t_q <= t2_q;
                            cand_d_q <= d2_q;
                            state_q  <= StDescend;
                        end else if (last2_q) begin
                            unvoiced_q <= 1'b1;
                        end
                    end
                    StDescend: begin
                        if (d2_q < cand_d_q) begin
                            cand_t_q <= t2_q;
                            cand_d_q <= d2_q;
                            if (last2_q) begin
                                tau_q       <= t2_q;
                                tau_valid_q <= 1'b1;
                                state_q     <= StAccum;
                            end
                        end else begin
                            tau_q       <= cand_t_q;
                            tau_valid_q <= 1'b1;
                            state_q     <= last2_q ? StAccum : StDrain;
                        end
                    end
                    StDrain: begin
                        if (last2_q) state_q <= StAccum;
                    end
                    default: state_q <= StAccum;
                endcase
            end
        end
    end

    assign pick_io.tau_out       = tau_q;
    assign pick_io.tau_valid_out = tau_valid_q;
    assign pick_io.unvoiced_out  = unvoiced_q;
endmodule

// File: tb/tb_yin_tau_picker.sv
// Self-checking bench for yin_tau_picker: directed frame table, reset sequence, random frames
// against a reference that finds the first below-threshold lag and follows its descending run.
module tb_yin_tau_picker;
    localparam int MaxLen  = 2048;
    localparam int MinTau  = 20;
    localparam int Latency = 2;  // edges between a beat's sampling edge and its output edge

    logic clk = 1'b0;
    logic rst = 1'b0;

    yin_tau_picker_if bus_if ();

    yin_tau_picker dut (
        .clk_in (clk),
        .rst_in (rst),
        .pick_io(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [7:0]  thr;
        bit          last_flag;
        int          dt0;
        logic [31:0] dv0;
        int          dt1;
        logic [31:0] dv1;
        int          dt2;
        logic [31:0] dv2;
        bit          voiced;
        int          tau;
        int          dec;
    } vec_t;

    logic [31:0] fr_d [MaxLen];
    bit   [1:0]  exp_ev  [int];
    logic [10:0] exp_val [int];
    logic [10:0] held = '0;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    string       cur_label = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s @edge %0d: got %0d expected %0d", cur_label, name, edge_n, act,
                     exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_tau"}, {21'd0, bus_if.tau_out}, 32'd0);
        check({name, "_pulses"}, {30'd0, bus_if.tau_valid_out, bus_if.unvoiced_out}, 32'd0);
    endtask

    // Advance one edge and compare outputs with what the schedule says for this edge
    task automatic step();
        bit [1:0] ev;
        @(posedge clk);
        #1;
        edge_n++;
        ev = 2'b00;
        if (exp_ev.exists(edge_n)) begin
            ev = exp_ev[edge_n];
            if (ev == 2'b10) held = exp_val[edge_n];
            exp_ev.delete(edge_n);
        end
        check("pulses", {30'd0, bus_if.tau_valid_out, bus_if.unvoiced_out}, {30'd0, ev});
        check("tau_out", {21'd0, bus_if.tau_out}, {21'd0, held});
    endtask

    function automatic void model(input int len, input logic [7:0] thr, output bit voiced,
                                  output int tau, output int dec);
        logic [63:0] s, p, q;
        int first, c;
        s = 0;
        first = -1;
        for (int t = 0; t < len; t++) begin
            if (t > 0) s += 64'(fr_d[t]);
            p = 64'(fr_d[t]) * 64'(t) * 64'd256;
            q = 64'(thr) * s;
            if (t >= MinTau && s != 0 && p < q) begin
                first = t;
                break;
            end
        end
        if (first < 0) begin
            voiced = 1'b0;
            tau = 0;
            dec = len - 1;
        end else begin
            c = first;
            while (c + 1 < len && fr_d[c+1] < fr_d[c]) c++;
            voiced = 1'b1;
            tau = c;
            dec = (c + 1 < len) ? c + 1 : c;
        end
    endfunction

    task automatic drive_frame(input int len, input logic [7:0] thr, input bit last_flag,
                               input bit voiced, input int tau, input int dec, input bit gaps,
                               input int stop_at);
        for (int t = 0; t < len; t++) begin
            if (t == stop_at) break;
            if (gaps && $urandom_range(0, 7) == 0) begin
                bus_if.diff_valid_in = 1'b0;
                bus_if.diff_last_in  = 1'b0;
                step();
            end
            bus_if.diff_in       = fr_d[t];
            bus_if.diff_valid_in = 1'b1;
            bus_if.diff_last_in  = last_flag && (t == len - 1);
            bus_if.threshold_in  = (t == 0) ? thr : 8'($urandom);
            step();
            if (t == dec) begin
                exp_ev[edge_n + Latency]  = voiced ? 2'b10 : 2'b01;
                exp_val[edge_n + Latency] = 11'(tau);
            end
        end
        bus_if.diff_valid_in = 1'b0;
        bus_if.diff_last_in  = 1'b0;
    endtask

    task automatic fill_vec(input vec_t v);
        for (int t = 0; t < MaxLen; t++) fr_d[t] = 32'd1000;
        if (v.dt0 >= 0) fr_d[v.dt0] = v.dv0;
        if (v.dt1 >= 0) fr_d[v.dt1] = v.dv1;
        if (v.dt2 >= 0) fr_d[v.dt2] = v.dv2;
    endtask

    vec_t vecs [7];

    initial begin
        vec_t        clean;
        int          len, lo, ndips, pos, tau, dec;
        bit          last_flag, voiced;
        logic [7:0]  thr;

        //          len   thr    last  dip0          dip1          dip2         voi tau  dec
        vecs[0] = '{2048, 8'd26, 1'b1, -1, 32'd0,  -1, 32'd0,   -1, 32'd0,   1'b0, 0,   2047};
        vecs[1] = '{2048, 8'd26, 1'b0, -1, 32'd0,  -1, 32'd0,   -1, 32'd0,   1'b0, 0,   2047};
        vecs[2] = '{2048, 8'd26, 1'b1, 100, 32'd5, -1, 32'd0,   -1, 32'd0,   1'b1, 100, 101};
        vecs[3] = '{2048, 8'd26, 1'b1, 100, 32'd50, 101, 32'd20, 102, 32'd900, 1'b1, 101, 102};
        vecs[4] = '{2048, 8'd26, 1'b1, 10, 32'd1,  300, 32'd5,  -1, 32'd0,   1'b1, 300, 301};
        vecs[5] = '{501,  8'd26, 1'b1, 500, 32'd2, -1, 32'd0,   -1, 32'd0,   1'b1, 500, 500};
        vecs[6] = '{2048, 8'd26, 1'b1, 100, 32'd5, -1, 32'd0,   -1, 32'd0,   1'b1, 100, 101};

        bus_if.diff_in       = '0;
        bus_if.diff_valid_in = 1'b0;
        bus_if.diff_last_in  = 1'b0;
        bus_if.threshold_in  = '0;

        // Asynchronous reset must act before any clock edge
        #1 rst = 1'b1;
        #2;
        cur_label = "reset";
        check_idle_outputs("async_reset");
        repeat (2) step();
        rst = 1'b0;

        // Directed frames, back to back
        for (int i = 0; i < 7; i++) begin
            cur_label = $sformatf("vec%0d", i);
            fill_vec(vecs[i]);
            drive_frame(vecs[i].len, vecs[i].thr, vecs[i].last_flag, vecs[i].voiced,
                        vecs[i].tau, vecs[i].dec, 1'b0, -1);
        end
        repeat (4) step();

        // Reset during beat 60 of a dip-at-100 frame: outputs clear at once, frame discarded
        cur_label = "midreset";
        clean = vecs[2];
        fill_vec(clean);
        drive_frame(clean.len, clean.thr, 1'b1, 1'b1, clean.tau, clean.dec, 1'b0, 61);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midframe_reset");
        held = '0;
        repeat (3) step();
        rst = 1'b0;
        cur_label = "after_reset";
        drive_frame(clean.len, clean.thr, 1'b1, 1'b1, clean.tau, clean.dec, 1'b0, -1);
        repeat (4) step();

        // Random frames with idle gaps, checked against the reference model
        for (int f = 0; f < 22; f++) begin
            cur_label = $sformatf("rand%0d", f);
            len = ($urandom_range(0, 3) == 0) ? MaxLen : int'($urandom_range(25, MaxLen - 1));
            last_flag = (len < MaxLen) ? 1'b1 : 1'($urandom_range(0, 1));
            lo = int'($urandom_range(100, 2000));
            for (int t = 0; t < MaxLen; t++) fr_d[t] = 32'(lo) + $urandom_range(0, lo / 4);
            ndips = int'($urandom_range(0, 3));
            for (int k = 0; k < ndips; k++) begin
                pos = int'($urandom_range(1, len - 1));
                fr_d[pos] = $urandom_range(0, lo / 8);
                if (pos + 1 < len && $urandom_range(0, 1) == 1) fr_d[pos+1] = fr_d[pos] / 2;
            end
            thr = 8'($urandom_range(0, 60));
            model(len, thr, voiced, tau, dec);
            drive_frame(len, thr, last_flag, voiced, tau, dec, 1'b1, -1);
        end
        repeat (5) step();

        cur_label = "end";
        check("pending_events", 32'(exp_ev.num()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
